// File: rtl/counter_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// counter_scheduler_pkg
//   Shared definitions for the counter scheduler block:
//     - state_t      : scheduler FSM encoding (IDLE / RUN / FIN)
//     - NREQ_DEF     : default number of requesters
//     - CW_DEF       : default counter width
//     - ptr_width()  : width of a requester index for a given NREQ
// ----------------------------------------------------------------------------
package counter_scheduler_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // A requester index always needs at least one bit, even for NREQ=1.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Scans the request vector starting at
//   index ptr and wrapping past NREQ-1; the first set request wins.
//   Ports:
//     req  in   NREQ  request vector
//     ptr  in   PW    index where the search starts (0..NREQ-1)
//     gnt  out  NREQ  one-hot winner, all zero when req is zero
// ----------------------------------------------------------------------------
module rr_arbiter
    import counter_scheduler_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    // One extra bit so ptr+offset (at most 2*NREQ-2) cannot overflow
    // before the modulo-NREQ wrap is applied.
    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, ptr} + (PW+1)'(off);
            idx = (sum >= NREQ_W) ? PW'(sum - NREQ_W) : PW'(sum);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// ----------------------------------------------------------------------------
// counter_scheduler
//   Shares one CW-bit up-counter among NREQ requesters. A round-robin
//   arbiter hands the counter to one requester per window; that requester's
//   LIMIT slice is latched at grant, the counter runs 0..limit, and the owner
//   receives a one-cycle done pulse. A window can be cancelled by abort or by
//   the owner dropping its request, in which case no done pulse is issued.
//   Ports:
//     clk    in   1        clock, rising edge
//     rst_n  in   1        asynchronous active-low reset
//     req    in   NREQ     level requests
//     limit  in   NREQ*CW  terminal counts, slice i = limit[i*CW +: CW]
//     abort  in   1        cancels the running window (ignored outside RUN)
//     gnt    out  NREQ     one-hot grant for the whole RUN phase
//     done   out  NREQ     one-cycle completion pulse to the owner
//     count  out  CW       counter value
//     busy   out  1        high while a window is running
// ----------------------------------------------------------------------------
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] limit,
    input  logic               abort,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [CW-1:0]      count,
    output logic               busy
);

    localparam int            PW   = ptr_width(NREQ);
    localparam logic [PW-1:0] LAST = PW'(NREQ-1);

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] owner, owner_nxt, owner_inc;
    logic [PW-1:0] arb_idx;
    logic [CW-1:0] lim, lim_nxt;
    logic [CW-1:0] count_nxt;

    logic [NREQ-1:0]         arb_gnt;
    logic [NREQ-1:0][CW-1:0] lim_arr;

    assign lim_arr = limit;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req  (req),
        .ptr  (ptr),
        .gnt  (arb_gnt)
    );

    // Encode the arbiter's one-hot result into an owner index.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) arb_idx = PW'(i);
        end
    end

    // Next search position after a window ends, wrapping at NREQ.
    assign owner_inc = (owner == LAST) ? '0 : owner + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            lim   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            lim   <= lim_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        lim_nxt   = lim;
        count_nxt = count;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt = arb_idx;
                    lim_nxt   = lim_arr[arb_idx];
                    count_nxt = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Cancel has priority over reaching the limit, so an abort
                // on the terminal cycle suppresses the done pulse.
                if (abort || !req[owner]) begin
                    ptr_nxt   = owner_inc;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else if (count == lim) begin
                    state_nxt = FIN;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            FIN: begin
                ptr_nxt   = owner_inc;
                count_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant and done are decoded from the registered owner, so they are
    // glitch-free, mutually exclusive and never more than one-hot.
    always_comb begin
        gnt  = '0;
        done = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i]  = (state == RUN) && (owner == PW'(i));
            done[i] = (state == FIN) && (owner == PW'(i));
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_counter_scheduler.sv
// ----------------------------------------------------------------------------
// tb_counter_scheduler
//   Directed scenarios with literal expectations, then a randomized run
//   checked against a window-level reference model of the scheduler.
// ----------------------------------------------------------------------------
module tb_counter_scheduler;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int OW   = 2*NREQ + CW + 1;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] limit;
    logic               abort;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [CW-1:0]      count;
    logic               busy;

    logic [OW-1:0] obs;
    assign obs = {gnt, done, count, busy};

    int checks   = 0;
    int failures = 0;

    // Reference model: window owner (-1 = none), finishing owner (-1 = none),
    // cycles elapsed in the window, latched limit, round-robin start.
    int m_owner, m_fin, m_elapsed, m_lim, m_ptr;

    counter_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .limit (limit),
        .abort (abort),
        .gnt   (gnt),
        .done  (done),
        .count (count),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] pk(input int g, input int d, input int c, input logic b);
        return {NREQ'(g), NREQ'(d), CW'(c), b};
    endfunction

    function automatic int oh(input int i);
        return (1 << i);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_fin = -1; m_elapsed = 0; m_lim = 0; m_ptr = 0;
    endtask

    // Advance the model by one clock using the inputs that the DUT will
    // sample on the coming edge.
    task automatic model_step();
        int idx;
        if (m_owner >= 0) begin
            if (abort || !req[m_owner]) begin
                m_ptr = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_elapsed = 0;
            end else if (m_elapsed == m_lim) begin
                m_fin = m_owner;
                m_owner = -1;
            end else begin
                m_elapsed++;
            end
        end else if (m_fin >= 0) begin
            m_ptr = (m_fin + 1) % NREQ;
            m_fin = -1;
            m_elapsed = 0;
        end else if (req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (m_owner < 0 && req[idx]) begin
                    m_owner = idx;
                    m_lim = int'(limit[idx*CW +: CW]);
                    m_elapsed = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [OW-1:0] e;
        rst_n = 1'b0; req = '0; limit = '0; abort = 1'b0;
        #1;
        e = pk(0, 0, 0, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL reset_async obs=%b exp=%b", obs, e); failures++; end
        @(negedge clk);
        checks++;
        if (obs !== e) begin $display("FAIL reset_hold obs=%b exp=%b", obs, e); failures++; end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== e) begin $display("FAIL reset_release cyc=%0d obs=%b exp=%b", i, obs, e); failures++; end
        end
    endtask

    task automatic test_single_window();
        logic [OW-1:0] e;
        req = NREQ'(1); limit[0 +: CW] = CW'(5);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e = pk(1, 0, c, 1'b1);
            checks++;
            if (obs !== e) begin $display("FAIL single_run c=%0d obs=%b exp=%b", c, obs, e); failures++; end
        end
        @(negedge clk);
        e = pk(0, 1, 5, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL single_done obs=%b exp=%b", obs, e); failures++; end
        req = '0;
        @(negedge clk);
        e = pk(0, 0, 0, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL single_idle obs=%b exp=%b", obs, e); failures++; end
    endtask

    task automatic test_round_robin();
        logic [OW-1:0] e;
        int o;
        rst_n = 1'b0; req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) limit[i*CW +: CW] = CW'(1);
        req = '1;
        for (int w = 0; w < 5; w++) begin
            o = w % NREQ;
            @(negedge clk);
            e = pk(oh(o), 0, 0, 1'b1);
            checks++;
            if (obs !== e) begin $display("FAIL rr_c0 win=%0d obs=%b exp=%b", w, obs, e); failures++; end
            @(negedge clk);
            e = pk(oh(o), 0, 1, 1'b1);
            checks++;
            if (obs !== e) begin $display("FAIL rr_c1 win=%0d obs=%b exp=%b", w, obs, e); failures++; end
            @(negedge clk);
            e = pk(0, oh(o), 1, 1'b0);
            checks++;
            if (obs !== e) begin $display("FAIL rr_fin win=%0d obs=%b exp=%b", w, obs, e); failures++; end
            @(negedge clk);
            e = pk(0, 0, 0, 1'b0);
            checks++;
            if (obs !== e) begin $display("FAIL rr_idle win=%0d obs=%b exp=%b", w, obs, e); failures++; end
            if (w == 4) req = '0;
        end
    endtask

    task automatic test_limit_latch();
        logic [OW-1:0] e;
        req = NREQ'(2); limit[CW +: CW] = CW'(0);
        @(negedge clk);
        e = pk(2, 0, 0, 1'b1);
        checks++;
        if (obs !== e) begin $display("FAIL latch_run obs=%b exp=%b", obs, e); failures++; end
        limit[CW +: CW] = CW'(9);
        @(negedge clk);
        e = pk(0, 2, 0, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL latch_done obs=%b exp=%b", obs, e); failures++; end
        req = '0;
        @(negedge clk);
        e = pk(0, 0, 0, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL latch_idle obs=%b exp=%b", obs, e); failures++; end
    endtask

    task automatic test_abort();
        logic [OW-1:0] e;
        req = NREQ'(4); limit[2*CW +: CW] = CW'(7); limit[3*CW +: CW] = CW'(0);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            e = pk(4, 0, c, 1'b1);
            checks++;
            if (obs !== e) begin $display("FAIL abort_run c=%0d obs=%b exp=%b", c, obs, e); failures++; end
        end
        abort = 1'b1;
        @(negedge clk);
        e = pk(0, 0, 0, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL abort_cancel obs=%b exp=%b", obs, e); failures++; end
        abort = 1'b0; req = '1;
        @(negedge clk);
        e = pk(8, 0, 0, 1'b1);
        checks++;
        if (obs !== e) begin $display("FAIL abort_next_ptr obs=%b exp=%b", obs, e); failures++; end
        req = '0;
        @(negedge clk);
        e = pk(0, 0, 0, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL req_drop_cancel obs=%b exp=%b", obs, e); failures++; end
        // abort on the terminal-count cycle: no done pulse
        req = NREQ'(2); limit[CW +: CW] = CW'(1);
        @(negedge clk);
        @(negedge clk);
        e = pk(2, 0, 1, 1'b1);
        checks++;
        if (obs !== e) begin $display("FAIL abort_lim_pre obs=%b exp=%b", obs, e); failures++; end
        abort = 1'b1;
        @(negedge clk);
        e = pk(0, 0, 0, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL abort_at_lim obs=%b exp=%b", obs, e); failures++; end
        abort = 1'b0; req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_window();
        logic [OW-1:0] e;
        req = NREQ'(4); limit[2*CW +: CW] = CW'(7);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            e = pk(4, 0, c, 1'b1);
            checks++;
            if (obs !== e) begin $display("FAIL midrst_run c=%0d obs=%b exp=%b", c, obs, e); failures++; end
        end
        #2 rst_n = 1'b0;
        #1;
        e = pk(0, 0, 0, 1'b0);
        checks++;
        if (obs !== e) begin $display("FAIL midrst_async obs=%b exp=%b", obs, e); failures++; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e = pk(4, 0, 0, 1'b1);
        checks++;
        if (obs !== e) begin $display("FAIL midrst_regrant obs=%b exp=%b", obs, e); failures++; end
        @(negedge clk);
        e = pk(4, 0, 1, 1'b1);
        checks++;
        if (obs !== e) begin $display("FAIL midrst_count obs=%b exp=%b", obs, e); failures++; end
        req = '0;
        @(negedge clk);
        // pointer is now 3; a reset must bring it back to 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; req = '1; limit[0 +: CW] = CW'(0);
        @(negedge clk);
        e = pk(1, 0, 0, 1'b1);
        checks++;
        if (obs !== e) begin $display("FAIL ptr_reset obs=%b exp=%b", obs, e); failures++; end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [OW-1:0] e;
        int eg, ed;
        rst_n = 1'b0; req = '0; abort = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 2500; n++) begin
            eg = (m_owner >= 0) ? oh(m_owner) : 0;
            ed = (m_fin >= 0) ? oh(m_fin) : 0;
            e = pk(eg, ed, m_elapsed, m_owner >= 0);
            checks++;
            if (obs !== e) begin $display("FAIL rand_model n=%0d obs=%b exp=%b", n, obs, e); failures++; end
            checks++;
            if (!$onehot0(gnt) || !$onehot0(done) || ((gnt & done) != '0)) begin
                $display("FAIL rand_invariant n=%0d gnt=%b done=%b", n, gnt, done); failures++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 5) == 0)
                    limit[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'(15) : CW'($urandom_range(0, 4));
            end
            abort = ($urandom_range(0, 19) == 0);
            model_step();
            @(negedge clk);
        end
        req = '0; abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_round_robin();
        test_limit_latch();
        test_abort();
        test_reset_mid_window();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
